ps2_keyboard: RTL and testbench

Memory-mapped PS/2 keyboard receiver on the CPU's I/O read path. It deserialises PS/2 device frames into scan-code bytes and queues them in a small FIFO. It presents the FIFO head to the CPU data-in mux whenever the CPU drives `io_rdn` low for an address in a000_0000–bfff_ffff. Each CPU `lw` from I/O space returns one status/data word and pops one byte.

---
 rtl/ps2_pkg.sv | 18 +
 rtl/ps2_keyboard_if.sv | 23 ++
 rtl/ps2_fifo.sv | 54 +++++
 rtl/ps2_keyboard.sv | 146 ++++++++++++++
 tb/tb_ps2_keyboard.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } ps2_state_e;

    localparam int unsigned FRAME_BITS      = 11;
    localparam int unsigned DATA_BITS       = 8;
    localparam int unsigned BIT_CNT_W       = $clog2(DATA_BITS);
    localparam int unsigned RDATA_W         = 32;
    localparam int unsigned RDATA_READY_BIT = 8;
    localparam int unsigned RDATA_OVF_BIT   = 9;

endpackage

// File: rtl/ps2_keyboard_if.sv
// CPU I/O read port of the PS/2 keyboard: read strobe in, status/data word out.
interface ps2_keyboard_if;

    logic                          io_rdn;
    logic [ps2_pkg::RDATA_W-1:0]   io_rdata;
    logic                          ready;
    logic                          overflow;

    modport master (
        output io_rdn,
        input  io_rdata,
        input  ready,
        input  overflow
    );

    modport slave (
        input  io_rdn,
        output io_rdata,
        output ready,
        output overflow
    );

endinterface

// File: rtl/ps2_fifo.sv
// Circular scan-code FIFO; a pop on a full FIFO frees a slot for a same-cycle push.
module ps2_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic                 cpu_clk,
    input  logic                 resetn,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] dout,
    output logic                 empty,
    output logic                 full
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    logic [DATA_BITS-1:0]  mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally at their DEPTH_LOG2 width.
    always_ff @(posedge cpu_clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronise, deframe, queue scan codes, serve CPU reads.
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned TIMEOUT    = 50000
) (
    input  logic           cpu_clk,
    input  logic           resetn,
    input  logic           ps2_clk,
    input  logic           ps2_data,
    ps2_keyboard_if.slave  cpu
);

    localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

    logic [2:0]           clk_sync;
    logic [1:0]           data_sync;
    logic                 fall;
    logic                 bit_in;

    ps2_state_e           state, state_n;
    logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par, par_n;
    logic                 push_c;
    logic [TCNT_W-1:0]    tcnt;
    logic                 timeout;

    logic                 rdn_q;
    logic                 pop_c;
    logic                 overflow;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [DATA_BITS-1:0] head;

    // Two-flop synchronisers; the third clock flop exposes falling edges.
    always_ff @(posedge cpu_clk or negedge resetn) begin
        if (!resetn) begin
            clk_sync  <= 3'b111;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    assign fall   = clk_sync[2] & ~clk_sync[1];
    assign bit_in = data_sync[1];

    // Idle-time counter, saturating so a stalled line never wraps into a false start.
    always_ff @(posedge cpu_clk or negedge resetn) begin
        if (!resetn)                      tcnt <= '0;
        else if (fall)                    tcnt <= '0;
        else if (tcnt != TCNT_W'(TIMEOUT)) tcnt <= tcnt + TCNT_W'(1);
    end

    assign timeout = (state != S_IDLE) && (tcnt == TCNT_W'(TIMEOUT));

    always_ff @(posedge cpu_clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par     <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            par     <= par_n;
        end
    end

    // Frame deserialiser; the byte is pushed on the stop-bit edge only if framing and odd parity hold.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        par_n     = par;
        push_c    = 1'b0;
        if (timeout) begin
            state_n = S_IDLE;
        end else if (fall) begin
            case (state)
                S_IDLE: begin
                    if (!bit_in) begin
                        state_n   = S_DATA;
                        bit_cnt_n = '0;
                    end
                end
                S_DATA: begin
                    shreg_n   = {bit_in, shreg[DATA_BITS-1:1]};
                    bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
                    if (bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) state_n = S_PARITY;
                end
                S_PARITY: begin
                    par_n   = bit_in;
                    state_n = S_STOP;
                end
                S_STOP: begin
                    push_c  = bit_in & (^{shreg, par});
                    state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // One pop per read strobe, on its first low cycle.
    always_ff @(posedge cpu_clk or negedge resetn) begin
        if (!resetn) rdn_q <= 1'b1;
        else         rdn_q <= cpu.io_rdn;
    end

    assign pop_c = ~cpu.io_rdn & rdn_q;

    always_ff @(posedge cpu_clk or negedge resetn) begin
        if (!resetn)                              overflow <= 1'b0;
        else if (push_c & fifo_full & ~pop_c)     overflow <= 1'b1;
        else if (pop_c)                           overflow <= 1'b0;
    end

    ps2_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .cpu_clk (cpu_clk),
        .resetn  (resetn),
        .push    (push_c),
        .din     (shreg),
        .pop     (pop_c),
        .dout    (head),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign cpu.ready    = ~fifo_empty;
    assign cpu.overflow = overflow;

    always_comb begin
        cpu.io_rdata                  = '0;
        cpu.io_rdata[DATA_BITS-1:0]   = head;
        cpu.io_rdata[RDATA_READY_BIT] = ~fifo_empty;
        cpu.io_rdata[RDATA_OVF_BIT]   = overflow;
    end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: framing, parity/stop errors, overflow, collision, timeout, reset.
module tb_ps2_keyboard;
    import ps2_pkg::*;

    localparam int unsigned TB_TIMEOUT = 100;
    localparam int          HP         = 8;   // PS/2 half period in cpu_clk cycles

    logic clk;
    logic resetn;
    logic ps2_clk;
    logic ps2_data;
    int   checks;
    int   errors;
    logic [31:0] w;

    ps2_keyboard_if bus ();

    ps2_keyboard #(
        .DEPTH_LOG2 (3),
        .TIMEOUT    (TB_TIMEOUT)
    ) dut (
        .cpu_clk  (clk),
        .resetn   (resetn),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .cpu      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [FRAME_BITS-1:0] mk_frame(input logic [7:0] d, input logic bad_par,
                                                       input logic stop);
        return {stop, ~(^d) ^ bad_par, d, 1'b0};
    endfunction

    // Present a bit and drop the PS/2 clock; returns just after the falling edge is driven.
    task automatic ps2_fall_half(input logic b);
        @(posedge clk); #1 ps2_data = b;
        repeat (HP - 1) @(posedge clk);
        #1 ps2_clk = 1'b0;
    endtask

    task automatic ps2_rise();
        repeat (HP) @(posedge clk);
        #1 ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [FRAME_BITS-1:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_fall_half(f[i]);
            ps2_rise();
        end
        @(posedge clk); #1 ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d);
        send_bits(mk_frame(d, 1'b0, 1'b1), FRAME_BITS);
    endtask

    // Strobe io_rdn low for len cycles; the word is captured just before the popping edge.
    task automatic cpu_read(output logic [31:0] word, input int len);
        @(posedge clk); #1 bus.io_rdn = 1'b0;
        @(negedge clk);
        word = bus.io_rdata;
        repeat (len) @(posedge clk);
        #1 bus.io_rdn = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        resetn      = 1'b0;
        ps2_clk     = 1'b1;
        ps2_data    = 1'b1;
        bus.io_rdn  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(bus.ready), 32'h0);
        check("reset_ovf", 32'(bus.overflow), 32'h0);
        check("reset_rdata", bus.io_rdata, 32'h0);
        resetn = 1'b1;
        repeat (2) @(posedge clk);

        // Valid frame 0x1C with precise push latency around the stop edge.
        send_bits(mk_frame(8'h1C, 1'b0, 1'b1), FRAME_BITS - 1);
        ps2_fall_half(1'b1);
        @(posedge clk); @(posedge clk); #1;
        check("stop_edge_ready_lo", 32'(bus.ready), 32'h0);
        @(posedge clk); #1;
        check("stop_edge_ready_hi", 32'(bus.ready), 32'h1);
        ps2_rise();
        check("valid_rdata_pre", bus.io_rdata, 32'h0000_011C);
        cpu_read(w, 1);
        check("valid_read", w, 32'h0000_011C);
        check("valid_ready_after", 32'(bus.ready), 32'h0);
        check("valid_rdata_after", bus.io_rdata, 32'h0);

        // Bad parity, then bad stop bit: nothing queued.
        send_bits(mk_frame(8'h1C, 1'b1, 1'b1), FRAME_BITS);
        send_bits(mk_frame(8'h32, 1'b0, 1'b0), FRAME_BITS);
        repeat (5) @(posedge clk); #1;
        check("bad_ready", 32'(bus.ready), 32'h0);
        check("bad_ovf", 32'(bus.overflow), 32'h0);

        // Nine frames into an eight-entry FIFO.
        for (int i = 1; i <= 9; i++) send_frame(8'(i));
        repeat (5) @(posedge clk); #1;
        check("ovf_flag", 32'(bus.overflow), 32'h1);
        check("ovf_rdata", bus.io_rdata, 32'h0000_0301);
        for (int i = 1; i <= 8; i++) begin
            cpu_read(w, 1);
            check($sformatf("ovf_read%0d", i), w, (i == 1) ? 32'h301 : (32'h100 | 32'(i)));
        end
        cpu_read(w, 1);
        check("ovf_read_empty", w, 32'h0);
        check("ovf_cleared", 32'(bus.overflow), 32'h0);

        // Full FIFO: a long read strobe lands on the stop-bit push edge.
        for (int i = 0; i < 8; i++) send_frame(8'(8'h10 + i));
        send_bits(mk_frame(8'h55, 1'b0, 1'b1), FRAME_BITS - 1);
        ps2_fall_half(1'b1);
        @(posedge clk); @(posedge clk); #1 bus.io_rdn = 1'b0;
        @(negedge clk);
        check("coll_read", bus.io_rdata, 32'h0000_0110);
        @(posedge clk); @(posedge clk); @(posedge clk); #1 bus.io_rdn = 1'b1;
        @(posedge clk); #1;
        check("coll_ovf", 32'(bus.overflow), 32'h0);
        check("coll_head", bus.io_rdata, 32'h0000_0111);
        ps2_rise();
        @(posedge clk); #1 ps2_data = 1'b1;
        for (int i = 1; i < 8; i++) begin
            cpu_read(w, 1);
            check($sformatf("coll_drain%0d", i), w, 32'h100 | 32'(8'h10 + i));
        end
        cpu_read(w, 1);
        check("coll_drain_pushed", w, 32'h0000_0155);
        check("coll_empty", 32'(bus.ready), 32'h0);

        // Partial frame abandoned by timeout, then a clean 0xF0.
        send_bits(mk_frame(8'hAA, 1'b0, 1'b1), 5);
        repeat (TB_TIMEOUT + 10) @(posedge clk);
        send_frame(8'hF0);
        repeat (5) @(posedge clk);
        cpu_read(w, 1);
        check("timeout_read", w, 32'h0000_01F0);
        check("timeout_empty", 32'(bus.ready), 32'h0);

        // Asynchronous reset mid-frame with a byte already queued.
        send_frame(8'h77);
        repeat (5) @(posedge clk); #1;
        check("prereset_ready", 32'(bus.ready), 32'h1);
        send_bits(mk_frame(8'h3C, 1'b0, 1'b1), 6);
        @(posedge clk); #1 resetn = 1'b0;
        #2;
        check("midreset_ready", 32'(bus.ready), 32'h0);
        check("midreset_ovf", 32'(bus.overflow), 32'h0);
        check("midreset_rdata", bus.io_rdata, 32'h0);
        @(posedge clk); #1 resetn = 1'b1;
        for (int i = 6; i < FRAME_BITS; i++) begin
            ps2_fall_half(mk_frame(8'h3C, 1'b0, 1'b1)[i]);
            ps2_rise();
        end
        @(posedge clk); #1 ps2_data = 1'b1;
        repeat (TB_TIMEOUT + 10) @(posedge clk); #1;
        check("postreset_empty", 32'(bus.ready), 32'h0);
        send_frame(8'h5A);
        repeat (5) @(posedge clk);
        cpu_read(w, 1);
        check("postreset_read", w, 32'h0000_015A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
